gate_response_checker: RTL and testbench

//  Receiving end of the gate stimulus flow: samples (a, b, y) vectors presented by a

---
 rtl/gate_response_checker.sv | 146 ++++++++++++++
 tb/tb_gate_response_checker.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_response_checker.sv
`default_nettype none
// ============================================================================
// Module      : gate_response_checker
// Description : On-chip self-check for a 2-input gate. Accepts (a, b, y)
//               vectors during a run and compares y against the selected
//               truth table. Tracks vector and mismatch counts, input-pair
//               coverage and the first failing vector, then reports a
//               registered pass/fail verdict or a timeout abort.
// Revision    : 1.0 - initial release
// ============================================================================
module gate_response_checker #(
  parameter int GATE        = 0,   // 0=AND 1=OR 2=XOR 3=NAND, others AND
  parameter int NUM_VECTORS = 4,   // vectors per run, >= 1
  parameter int CNT_W       = 8,   // NUM_VECTORS < 2**CNT_W
  parameter int TIMEOUT     = 16   // idle RUN cycles before abort, >= 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             a,
  input  logic             b,
  input  logic             y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic [3:0]       cov,
  output logic [2:0]       first_err
);

  localparam int                c_IDLE_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_IDLE_W-1:0] c_IDLE_LAST = c_IDLE_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  c_NUM       = CNT_W'(NUM_VECTORS);
  localparam logic [CNT_W-1:0]  c_ERR_MAX   = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_vec;
  logic [CNT_W-1:0]    r_err;
  logic [3:0]          r_cov;
  logic [2:0]          r_first;
  logic                r_pass;
  logic                r_timeout;
  logic [c_IDLE_W-1:0] r_idle;

  logic                w_accept;
  logic                w_exp;
  logic                w_mismatch;
  logic [CNT_W-1:0]    w_vec_nxt;
  logic [CNT_W-1:0]    w_err_nxt;
  logic [3:0]          w_cov_nxt;
  logic                w_last;

  // Expected gate output for the presented input pair
  always_comb begin
    w_exp = a & b;
    case (GATE)
      1:       w_exp = a | b;
      2:       w_exp = a ^ b;
      3:       w_exp = ~(a & b);
      default: w_exp = a & b;
    endcase
  end

  assign w_accept   = in_valid && (r_state == S_RUN);
  assign w_mismatch = (y != w_exp);
  assign w_vec_nxt  = r_vec + 1'b1;
  // Error count sticks at all-ones rather than wrapping back to a clean zero
  assign w_err_nxt  = (w_mismatch && (r_err != c_ERR_MAX)) ? r_err + 1'b1 : r_err;
  assign w_cov_nxt  = r_cov | (4'b0001 << {a, b});
  assign w_last     = (w_vec_nxt == c_NUM);

  // Run control, statistics and verdict, all advanced on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_vec     <= '0;
      r_err     <= '0;
      r_cov     <= '0;
      r_first   <= '0;
      r_pass    <= 1'b0;
      r_timeout <= 1'b0;
      r_idle    <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state   <= S_RUN;
            r_vec     <= '0;
            r_err     <= '0;
            r_cov     <= '0;
            r_first   <= '0;
            r_pass    <= 1'b0;
            r_timeout <= 1'b0;
            r_idle    <= '0;
          end
        end
        S_RUN: begin
          if (w_accept) begin
            // An accept always wins over a timeout in the same cycle
            r_vec  <= w_vec_nxt;
            r_err  <= w_err_nxt;
            r_cov  <= w_cov_nxt;
            r_idle <= '0;
            if (w_mismatch && (r_err == '0)) begin
              r_first <= {a, b, y};
            end
            if (w_last) begin
              r_state <= S_DONE;
              r_pass  <= (w_err_nxt == '0) && (w_cov_nxt == 4'b1111);
            end
          end else if (r_idle == c_IDLE_LAST) begin
            r_state   <= S_DONE;
            r_timeout <= 1'b1;
            r_pass    <= 1'b0;
          end else begin
            r_idle <= r_idle + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Status flags decode directly from the state register
  assign in_ready  = (r_state == S_RUN);
  assign busy      = (r_state == S_RUN);
  assign done      = (r_state == S_DONE);
  assign pass      = r_pass;
  assign timeout   = r_timeout;
  assign vec_count = r_vec;
  assign err_count = r_err;
  assign cov       = r_cov;
  assign first_err = r_first;

endmodule
`default_nettype wire

// File: tb/tb_gate_response_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_gate_response_checker
// Description : Directed bench for gate_response_checker. Three instances
//               (AND, XOR, NAND) see identical stimulus; a reference model
//               pushes the expected end-of-run statistics into a scoreboard
//               that is popped when the checker raises done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gate_response_checker;

  localparam int c_NUMV    = 4;
  localparam int c_TIMEOUT = 16;
  localparam int c_N       = 3;

  typedef struct packed {
    logic [7:0] vec;
    logic [7:0] err;
    logic [3:0] cov;
    logic [2:0] fe;
    logic       pass;
    logic       to;
  } exp_t;

  logic clk = 1'b0;
  logic rst, start, in_valid, a, b, y;

  logic       rdy   [c_N];
  logic       busy  [c_N];
  logic       done  [c_N];
  logic       pass_o[c_N];
  logic       to_o  [c_N];
  logic [7:0] vc    [c_N];
  logic [7:0] ec    [c_N];
  logic [3:0] cv    [c_N];
  logic [2:0] fe    [c_N];

  int n_chk = 0;
  int n_err = 0;

  // Reference model state
  bit         m_run = 1'b0;
  int         m_idle = 0;
  int         m_vec [c_N];
  int         m_err [c_N];
  logic [3:0] m_cov [c_N];
  logic [2:0] m_fe  [c_N];
  exp_t       sb[$];
  exp_t       last [c_N];

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < c_N; gi++) begin : g_dut
      localparam int c_G = (gi == 0) ? 0 : (gi == 1) ? 2 : 3;
      gate_response_checker #(
        .GATE(c_G), .NUM_VECTORS(c_NUMV), .CNT_W(8), .TIMEOUT(c_TIMEOUT)
      ) u_dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .in_ready(rdy[gi]), .a(a), .b(b), .y(y),
        .busy(busy[gi]), .done(done[gi]), .pass(pass_o[gi]),
        .timeout(to_o[gi]), .vec_count(vc[gi]), .err_count(ec[gi]),
        .cov(cv[gi]), .first_err(fe[gi])
      );
    end
  endgenerate

  // Truth tables indexed by {a,b}: instance 0 AND, 1 XOR, 2 NAND
  function automatic logic exp_y(input int i, input logic va, input logic vb);
    logic [3:0] t;
    case (i)
      0:       t = 4'b1000;
      1:       t = 4'b0110;
      default: t = 4'b0111;
    endcase
    return t[{va, vb}];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < c_N; i++) begin
      m_vec[i] = 0; m_err[i] = 0; m_cov[i] = 4'b0; m_fe[i] = 3'b0;
    end
    m_idle = 0;
  endtask

  task automatic finish_run(input bit to);
    exp_t e;
    for (int i = 0; i < c_N; i++) begin
      e.vec  = 8'(m_vec[i]);
      e.err  = 8'(m_err[i]);
      e.cov  = m_cov[i];
      e.fe   = m_fe[i];
      e.to   = to;
      e.pass = !to && (m_err[i] == 0) && (m_cov[i] == 4'b1111);
      sb.push_back(e);
    end
    m_run = 1'b0;
  endtask

  task automatic account_idle();
    if (m_run) begin
      m_idle++;
      if (m_idle == c_TIMEOUT) finish_run(1'b1);
    end
  endtask

  task automatic tick();
    in_valid = 1'b0; start = 1'b0;
    account_idle();
    @(negedge clk);
    chk("busy_tick", busy[0], m_run);
  endtask

  task automatic send(input logic va, input logic vb, input logic vy);
    bit acc;
    in_valid = 1'b1; start = 1'b0; a = va; b = vb; y = vy;
    #1;
    chk("in_ready", rdy[0], m_run);
    acc = m_run;
    if (acc) begin
      m_idle = 0;
      for (int i = 0; i < c_N; i++) begin
        m_vec[i]++;
        m_cov[i][{va, vb}] = 1'b1;
        if (vy !== exp_y(i, va, vb)) begin
          if (m_err[i] == 0) m_fe[i] = {va, vb, vy};
          m_err[i]++;
        end
      end
      if (m_vec[0] == c_NUMV) finish_run(1'b0);
    end
    @(negedge clk);
    chk("busy_send", busy[0], m_run);
  endtask

  task automatic start_run();
    bit was;
    in_valid = 1'b0; start = 1'b1;
    was = m_run;
    account_idle();
    if (!was) begin
      model_clear();
      m_run = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    chk("busy_start", busy[0], m_run);
  endtask

  task automatic pulse_rst();
    in_valid = 1'b0; start = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_run = 1'b0;
    model_clear();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " vec"},   vc[0],     0);
    chk({tag, " err"},   ec[0],     0);
    chk({tag, " cov"},   cv[0],     0);
    chk({tag, " fe"},    fe[0],     0);
    chk({tag, " pass"},  pass_o[0], 0);
    chk({tag, " to"},    to_o[0],   0);
    chk({tag, " done"},  done[0],   0);
    chk({tag, " busy"},  busy[0],   0);
    chk({tag, " ready"}, rdy[0],    0);
  endtask

  task automatic check_stats(input string tag);
    for (int i = 0; i < c_N; i++) begin
      chk($sformatf("%s[%0d] vec", tag, i),  vc[i],     last[i].vec);
      chk($sformatf("%s[%0d] err", tag, i),  ec[i],     last[i].err);
      chk($sformatf("%s[%0d] cov", tag, i),  cv[i],     last[i].cov);
      chk($sformatf("%s[%0d] fe", tag, i),   fe[i],     last[i].fe);
      chk($sformatf("%s[%0d] pass", tag, i), pass_o[i], last[i].pass);
      chk($sformatf("%s[%0d] to", tag, i),   to_o[i],   last[i].to);
    end
  endtask

  // Verdict must already be up on entry; wait a bounded time only to resync
  task automatic check_done(input string tag);
    in_valid = 1'b0;
    chk({tag, " done_lat"}, done[0], 1);
    for (int n = 0; n < 40 && done[0] !== 1'b1; n++) @(negedge clk);
    if (sb.size() < c_N) begin
      chk({tag, " sb_depth"}, 32'(sb.size()), c_N);
      return;
    end
    for (int i = 0; i < c_N; i++) last[i] = sb.pop_front();
    check_stats(tag);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; a = 1'b0; b = 1'b0; y = 1'b0;
    model_clear();
    @(negedge clk); @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // 1: correct AND table back-to-back
    start_run();
    send(0, 0, 0); send(0, 1, 0); send(1, 0, 0); send(1, 1, 1);
    check_done("t1");
    // stats hold in DONE; vectors there are refused
    send(1, 1, 0); tick(); tick();
    check_stats("t1_hold");

    // 2: two mismatches, first is 11/0
    start_run();
    send(0, 0, 0); send(1, 1, 0); send(1, 0, 0); send(0, 1, 1);
    check_done("t2");

    // 3: partial coverage
    start_run();
    send(0, 0, 0); send(1, 1, 1); send(0, 0, 0); send(1, 1, 1);
    check_done("t3");

    // 4a: timeout after 16 idle cycles
    start_run();
    send(0, 0, 0); send(0, 1, 0);
    repeat (c_TIMEOUT) tick();
    check_done("t4a");
    // 4b: accept lands on the 16th idle cycle
    start_run();
    send(0, 0, 0); send(0, 1, 0);
    repeat (c_TIMEOUT - 1) tick();
    send(1, 0, 0); send(1, 1, 1);
    check_done("t4b");

    // 5: reset mid-run, IDLE refusal, start ignored in RUN, restart from DONE
    start_run();
    send(0, 0, 0); send(1, 1, 1);
    pulse_rst();
    check_zero("t5_rst");
    send(1, 1, 1); tick();
    chk("t5_idle vec", vc[0], 0);
    start_run();
    send(0, 0, 1);
    start_run();
    send(0, 1, 0); send(1, 0, 0); send(1, 1, 1);
    check_done("t5_run");
    start_run();
    chk("t5_restart vec", vc[0], 0);
    chk("t5_restart fe",  fe[0], 0);
    chk("t5_restart cov", cv[0], 0);
    chk("t5_restart done", done[0], 0);

    // 6: XOR table, then NAND table
    send(0, 0, 0); send(0, 1, 1); send(1, 0, 1); send(1, 1, 0);
    check_done("t6_xor");
    chk("t6_and_err_nonzero", 32'(ec[0] != 8'd0), 1);
    start_run();
    send(0, 0, 1); send(0, 1, 1); send(1, 0, 1); send(1, 1, 0);
    check_done("t6_nand");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
